// File: rtl/asic_padcfg_pkg.sv
// Shared types and constants for the pad configuration controller.
package asic_padcfg_pkg;

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StIsolate  = 3'd1,
    StEnable   = 3'd2,
    StRun      = 3'd3,
    StFreeze   = 3'd4,
    StUnfreeze = 3'd5
  } state_e;

  localparam int unsigned BitHldHN        = 0;
  localparam int unsigned BitEnableH      = 1;
  localparam int unsigned BitEnableInpH   = 2;
  localparam int unsigned BitEnableVddaH  = 3;
  localparam int unsigned BitEnableVswH   = 4;
  localparam int unsigned BitEnableVddio  = 5;
  localparam int unsigned BitIbModeSel    = 6;
  localparam int unsigned BitVtripSel     = 7;
  localparam int unsigned BitSlow         = 8;
  localparam int unsigned BitHldOvr       = 9;
  localparam int unsigned BitAnalogEn     = 10;
  localparam int unsigned BitAnalogSel    = 11;
  localparam int unsigned BitAnalogPol    = 12;
  localparam int unsigned BitDmLsb        = 13;

  localparam logic [15:0] PADCFG_RESET = 16'hC020;
  localparam logic [15:0] PADCFG_WMASK = 16'hFFFC;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/asic_padcfg_regs.sv
// Per-pad shadow registers, read mux, error decode and registered response.
module asic_padcfg_regs
  import asic_padcfg_pkg::*;
#(
  parameter int unsigned NPADS = 8,
  parameter int unsigned AW    = $clog2(NPADS + 1)
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   accept,
  input  logic                   reg_write,
  input  logic [AW-1:0]          reg_addr,
  input  logic [15:0]            reg_wdata,
  input  logic [1:0]             ctl_bits,
  input  logic [3:0]             status,
  output logic [NPADS-1:0][15:0] shadow,
  output logic                   rsp_valid,
  output logic [15:0]            rsp_rdata,
  output logic                   rsp_err
);

  logic [NPADS-1:0][15:0] shadow_q;
  logic                   is_pad;
  logic                   is_status;
  logic [15:0]            rdata_d;
  logic                   err_d;

  assign is_pad    = (reg_addr < AW'(NPADS));
  assign is_status = (reg_addr == AW'(NPADS));
  assign shadow    = shadow_q;

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (is_pad) begin
      for (int i = 0; i < NPADS; i++) begin
        if (reg_addr == AW'(i)) rdata_d = shadow_q[i] | {14'b0, ctl_bits};
      end
    end else if (is_status) begin
      rdata_d = {12'b0, status};
      err_d   = reg_write;
    end else begin
      err_d = 1'b1;
    end
    if (reg_write) rdata_d = '0;
  end

  // Bits 1:0 are never stored; they are merged from the FSM on every read.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < NPADS; i++) shadow_q[i] <= PADCFG_RESET & PADCFG_WMASK;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NPADS; i++) begin
        if (accept && reg_write && is_pad && reg_addr == AW'(i)) begin
          shadow_q[i] <= reg_wdata & PADCFG_WMASK;
        end
      end
      rsp_valid <= accept;
      rsp_rdata <= accept ? rdata_d : 16'h0000;
      rsp_err   <= accept & err_d;
    end
  end

endmodule

// File: rtl/asic_padcfg_ctrl.sv
// Pad power-up / retention sequencer driving the per-pad tech_cfg vectors.
module asic_padcfg_ctrl
  import asic_padcfg_pkg::*;
#(
  parameter int unsigned NPADS         = 8,
  parameter int unsigned CFGW          = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned AW            = $clog2(NPADS + 1)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  reg_valid,
  output logic                  reg_ready,
  input  logic                  reg_write,
  input  logic [AW-1:0]         reg_addr,
  input  logic [15:0]           reg_wdata,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  input  logic                  hold_req,
  output logic                  pads_ready,
  output logic [NPADS*CFGW-1:0] pad_cfg
);

  localparam int unsigned CW = $clog2(max_u(SETTLE_CYCLES, HOLD_CYCLES) + 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             ctl;
  logic                   accept;
  logic [NPADS-1:0][15:0] shadow;

  assign accept = reg_valid & reg_ready;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:    state_d = StIsolate;
      StIsolate:  if (cnt_q == '0) state_d = StEnable;
      StEnable:   if (cnt_q == '0) state_d = hold_req ? StFreeze : StRun;
      StRun:      if (hold_req) state_d = StFreeze;
      StFreeze:   if (!hold_req) state_d = StUnfreeze;
      StUnfreeze: begin
        if (hold_req)          state_d = StFreeze;
        else if (cnt_q == '0)  state_d = StRun;
      end
      default:    state_d = StReset;
    endcase

    // Dwell counter reloads with (dwell - 1) on entry and exits at zero.
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        StIsolate:            cnt_d = CW'(SETTLE_CYCLES - 1);
        StEnable, StUnfreeze: cnt_d = CW'(HOLD_CYCLES - 1);
        default:              cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    ctl        = 2'b00;
    pads_ready = 1'b0;
    reg_ready  = 1'b1;
    unique case (state_q)
      StReset:                       reg_ready = 1'b0;
      StIsolate:                     ctl = 2'b00;
      StEnable, StFreeze, StUnfreeze: ctl[BitEnableH] = 1'b1;
      StRun: begin
        ctl[BitEnableH] = 1'b1;
        ctl[BitHldHN]   = 1'b1;
        pads_ready      = 1'b1;
      end
      default:                       reg_ready = 1'b0;
    endcase

    for (int k = 0; k < NPADS; k++) begin
      pad_cfg[k*CFGW +: CFGW] = (state_q == StReset) ? '0 : (shadow[k] | {14'b0, ctl});
    end
  end

  asic_padcfg_regs #(
    .NPADS (NPADS),
    .AW    (AW)
  ) u_regs (
    .clk       (clk),
    .nreset    (nreset),
    .accept    (accept),
    .reg_write (reg_write),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .ctl_bits  (ctl),
    .status    ({state_q, pads_ready}),
    .shadow    (shadow),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_asic_padcfg_ctrl.sv
// Directed bench for asic_padcfg_ctrl with SETTLE_CYCLES=4, HOLD_CYCLES=2.
module tb_asic_padcfg_ctrl;

  localparam int unsigned NPADS = 8;
  localparam int unsigned CFGW  = 16;
  localparam int unsigned AW    = 4;

  logic                  clk = 1'b0;
  logic                  nreset;
  logic                  reg_valid;
  logic                  reg_ready;
  logic                  reg_write;
  logic [AW-1:0]         reg_addr;
  logic [15:0]           reg_wdata;
  logic                  rsp_valid;
  logic [15:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  hold_req;
  logic                  pads_ready;
  logic [NPADS*CFGW-1:0] pad_cfg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asic_padcfg_ctrl #(
    .NPADS         (NPADS),
    .CFGW          (CFGW),
    .SETTLE_CYCLES (4),
    .HOLD_CYCLES   (2),
    .AW            (AW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .reg_valid  (reg_valid),
    .reg_ready  (reg_ready),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .hold_req   (hold_req),
    .pads_ready (pads_ready),
    .pad_cfg    (pad_cfg)
  );

  function automatic logic [15:0] pad(input int k);
    return pad_cfg[k*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    reg_valid = 1'b1;
    reg_write = w;
    reg_addr  = a;
    reg_wdata = d;
    step();
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  initial begin
    logic [1:0] eb;
    nreset    = 1'b0;
    reg_valid = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    hold_req  = 1'b0;
    repeat (3) step();
    chk("rst_pad_cfg", pad_cfg, '0);
    chk("rst_reg_ready", reg_ready, 0);
    chk("rst_pads_ready", pads_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);

    // Power-up: 00 for cycles 1-4, 10 for 5-6, 11 from 7.
    nreset = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      eb = (cyc <= 4) ? 2'b00 : (cyc <= 6) ? 2'b10 : 2'b11;
      chk($sformatf("pwr_pad0_c%0d", cyc), pad(0), {112'b0, 16'hC020 | {14'b0, eb}});
      chk($sformatf("pwr_ready_c%0d", cyc), pads_ready, (cyc >= 7) ? 1 : 0);
    end
    chk("run_reg_ready", reg_ready, 1);

    req(1'b1, 4'd3, 16'h0105);
    chk("wr3_valid", rsp_valid, 1);
    chk("wr3_err", rsp_err, 0);
    chk("wr3_rdata", rsp_rdata, 0);
    chk("wr3_pad3", pad(3), 16'h0107);
    chk("wr3_pad2", pad(2), 16'hC023);
    req(1'b0, 4'd3, 16'h0);
    chk("rd3_rdata", rsp_rdata, 16'h0107);
    req(1'b1, 4'd5, 16'h1234);
    req(1'b0, 4'd5, 16'h0);
    chk("rd5_after_wr", rsp_rdata, 16'h1237);
    step();
    chk("idle_rsp_valid", rsp_valid, 0);
    req(1'b0, 4'd8, 16'h0);
    chk("status_run", rsp_rdata, 16'h0007);
    chk("status_run_err", rsp_err, 0);

    // Five-cycle hold pulse with a write during FREEZE.
    hold_req = 1'b1;
    step();
    chk("frz_pad0", pad(0), 16'hC022);
    chk("frz_ready", pads_ready, 0);
    req(1'b0, 4'd8, 16'h0);
    chk("status_frz", rsp_rdata, 16'h0008);
    req(1'b1, 4'd2, 16'hA5A8);
    chk("frz_wr_pad2", pad(2), 16'hA5AA);
    step();
    step();
    chk("frz_e5_pad0", pad(0), 16'hC022);
    hold_req = 1'b0;
    step();
    chk("unfrz_e6_pad0", pad(0), 16'hC022);
    chk("unfrz_e6_ready", pads_ready, 0);
    step();
    chk("unfrz_e7_pad0", pad(0), 16'hC022);
    step();
    chk("rerun_pad0", pad(0), 16'hC023);
    chk("rerun_pad2", pad(2), 16'hA5AB);
    chk("rerun_ready", pads_ready, 1);

    // Address errors.
    req(1'b0, 4'd9, 16'h0);
    chk("oor_rd_valid", rsp_valid, 1);
    chk("oor_rd_err", rsp_err, 1);
    chk("oor_rd_rdata", rsp_rdata, 0);
    req(1'b1, 4'd8, 16'hFFFF);
    chk("wr_status_err", rsp_err, 1);
    req(1'b0, 4'd8, 16'h0);
    chk("status_after_wr", rsp_rdata, 16'h0007);
    req(1'b1, 4'd15, 16'hFFFF);
    chk("oor_wr_err", rsp_err, 1);
    chk("oor_wr_pad7", pad(7), 16'hC023);
    chk("oor_wr_pad0", pad(0), 16'hC023);

    // hold_req held through power-up: ENABLE exits into FREEZE.
    nreset   = 1'b0;
    hold_req = 1'b1;
    step();
    chk("rst2_pad_cfg", pad_cfg, '0);
    nreset = 1'b1;
    repeat (6) step();
    chk("hpu_enable_pad2", pad(2), 16'hC022);
    step();
    chk("hpu_frz_pad0", pad(0), 16'hC022);
    chk("hpu_frz_ready", pads_ready, 0);
    req(1'b0, 4'd8, 16'h0);
    chk("hpu_status", rsp_rdata, 16'h0008);
    repeat (3) step();
    chk("hpu_frz_ready_late", pads_ready, 0);
    hold_req = 1'b0;
    step();
    chk("hpu_unfrz1_ready", pads_ready, 0);
    step();
    chk("hpu_unfrz2_ready", pads_ready, 0);
    step();
    chk("hpu_run_ready", pads_ready, 1);

    // Reset in ENABLE with a read being presented.
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    step();
    req(1'b1, 4'd3, 16'h1110);
    chk("iso_wr_pad3", pad(3), 16'h1110);
    repeat (3) step();
    chk("en_pad3", pad(3), 16'h1112);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = 4'd3;
    nreset    = 1'b0;
    step();
    reg_valid = 1'b0;
    chk("midrst_pad_cfg", pad_cfg, '0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    chk("midrst_reg_ready", reg_ready, 0);
    nreset = 1'b1;
    repeat (7) step();
    chk("midrst_run_ready", pads_ready, 1);
    chk("midrst_pad3", pad(3), 16'hC023);
    req(1'b0, 4'd3, 16'h0);
    chk("midrst_rd3", rsp_rdata, 16'hC023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/asic_padcfg_ctrl.md
# asic_padcfg_ctrl

Core-side controller that generates the per-pad `tech_cfg` control vectors consumed by the sky130 GPIO pad wrappers in the padring. It owns the pad power-up sequence (outputs isolated, then enabled, then hold released), retention hold entry and exit for low-power modes, and a small register interface through which firmware sets each pad's drive, slew, trip point and analog fields. Its outputs connect directly to the `tech_cfg[15:0]` inputs of each pad instance, one vector per pad.

## Interface
Parameters:
- `NPADS`, 8: number of controlled pads.
- `CFGW`, 16: per-pad control vector width; fixed at 16.
- `SETTLE_CYCLES`, 64: cycles spent in ISOLATE; must be ≥1.
- `HOLD_CYCLES`, 16: cycles spent in ENABLE and UNFREEZE; must be ≥1.
- `AW`, `$clog2(NPADS+1)`: register address width.

Ports:
- `clk` in 1: single clock.
- `nreset` in 1: reset, **synchronous, active-low** (already decided; one clock domain).
- `reg_valid` in 1: request valid.
- `reg_ready` out 1: request accepted when `reg_valid & reg_ready`.
- `reg_write` in 1: 1 = write, 0 = read.
- `reg_addr` in AW: 0..NPADS-1 selects a pad configuration register; NPADS selects STATUS.
- `reg_wdata` in 16: write data.
- `rsp_valid` out 1: response pulse, one cycle after acceptance.
- `rsp_rdata` out 16: read data; 0 on writes.
- `rsp_err` out 1: address out of range, or a write to STATUS.
- `hold_req` in 1: level request to freeze all pads (retention).
- `pads_ready` out 1: high only in RUN.
- `pad_cfg` out NPADS*CFGW: pad k occupies bits [k*16+15 : k*16].

## Operation
- Per-pad field map: bit0 HLD_H_N, bit1 ENABLE_H, bit2 ENABLE_INP_H, bit3 ENABLE_VDDA_H, bit4 ENABLE_VSWITCH_H, bit5 ENABLE_VDDIO, bit6 IB_MODE_SEL, bit7 VTRIP_SEL, bit8 SLOW, bit9 HLD_OVR, bit10 ANALOG_EN, bit11 ANALOG_SEL, bit12 ANALOG_POL, bits15:13 DM.
- Each pad has a shadow register. Only bits 15:2 are writable; bits 1:0 always read back the FSM-driven values. Reset value is 16'hC020 (DM=110, ENABLE_VDDIO=1).
- The FSM drives bits 1:0 of every pad:
  - RESET: all of `pad_cfg` = 0.
  - ISOLATE: ENABLE_H=0, HLD_H_N=0.
  - ENABLE: ENABLE_H=1, HLD_H_N=0.
  - RUN: both bits = 1.
  - FREEZE: ENABLE_H=1, HLD_H_N=0.
  - UNFREEZE: ENABLE_H=1, HLD_H_N=0.
- Outside RESET, `pad_cfg` bits 15:2 equal the shadow registers.
- State transitions:
  - RESET → ISOLATE on the first edge with `nreset`=1.
  - ISOLATE → ENABLE after SETTLE_CYCLES.
  - ENABLE → RUN after HOLD_CYCLES, or → FREEZE if `hold_req`=1 at that exit edge.
  - RUN → FREEZE when `hold_req`=1.
  - FREEZE → UNFREEZE when `hold_req`=0.
  - UNFREEZE → RUN after HOLD_CYCLES; → FREEZE if `hold_req` reasserts.
- The dwell counter reloads on every state entry. Its width is `$clog2(max(SETTLE_CYCLES,HOLD_CYCLES)+1)`.
- Register writes are accepted in every state except RESET and take effect on `pad_cfg` the cycle after acceptance. Writes made during FREEZE are therefore latched by the pads only after UNFREEZE.
- STATUS read returns {12'b0, state[2:0], pads_ready}. State encoding: RESET=0, ISOLATE=1, ENABLE=2, RUN=3, FREEZE=4, UNFREEZE=5.
- Out-of-range address: a write is dropped and a read returns 0; both set `rsp_err`.

## Timing
- `reg_ready` = 1 in every state except RESET. There is no backpressure beyond that, so one request is accepted per cycle.
- `rsp_valid`, `rsp_rdata` and `rsp_err` are registered and appear exactly 1 cycle after acceptance.
- A read in the cycle after a write to the same address returns the new value.
- Reset values: `pad_cfg`=0, `pads_ready`=0, `reg_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, shadows=16'hC020.
- Asserting `nreset`=0 in any state returns to RESET at the next edge. All outputs are then 0, and any pending response is dropped.
- Power-up sequence, with cycle 1 being the first edge with `nreset`=1:
  - ISOLATE spans cycles 1..SETTLE_CYCLES.
  - ENABLE spans the next HOLD_CYCLES cycles.
  - `pads_ready` rises at cycle SETTLE_CYCLES+HOLD_CYCLES+1.
- `hold_req` is sampled every cycle. In RUN, HLD_H_N falls on the edge after `hold_req` is first seen high.

## Structure
- Package `asic_padcfg_pkg` holds:
  - state enum;
  - field bit-position constants;
  - `PADCFG_RESET` = 16'hC020;
  - `PADCFG_WMASK` = 16'hFFFC.
- One sub-module, `asic_padcfg_regs`: the shadow register file plus read mux and error decode.
- The FSM, counter and output assembly live in the top module.

## Test plan
- Power-up with SETTLE=4, HOLD=2: release `nreset` → `pad_cfg[1:0]` = 00 for cycles 1–4, 10 for cycles 5–6, 11 from cycle 7; `pads_ready`=1 from cycle 7.
- In RUN, write pad 3 with 16'h0105 → pad 3 bits 15:0 = 16'h0107 the next cycle; a read of pad 3 returns 16'h0107; other pads stay 16'hC023.
- Pulse `hold_req` for 5 cycles in RUN → HLD_H_N=0 for all pads for 5 + HOLD_CYCLES cycles. A write during FREEZE appears in bits 15:2 and is retained.
- Read address NPADS+1 → `rsp_err`=1, `rsp_rdata`=0. Write to STATUS → `rsp_err`=1 and no state change.
- `hold_req`=1 throughout power-up → ENABLE exits to FREEZE; `pads_ready` never rises until `hold_req`=0 plus HOLD_CYCLES.
- `nreset`=0 mid-ENABLE with a read outstanding → next edge `pad_cfg`=0, `rsp_valid`=0, shadows=16'hC020.
